// File: rtl/mem_access_unit.sv
// Data-memory access unit for the MEM stage.
// Owns a byte-addressed little-endian word memory. Every aligned pipeline
// access takes MEM_LATENCY cycles in BUSY, then one DONE cycle. Loads are
// sign- or zero-extended, stores write byte lanes, and misaligned requests
// are rejected. A debug port reads whole words when the FSM is idle.
//
// Handshake: a request is i_valid & (i_mem_read | i_mem_write). The pipeline
// holds the request stable until o_done. o_stall is the inverse of "ready":
// while it is high the pipeline must not advance. o_done (one cycle) marks
// the cycle in which the pipeline may advance. o_addr_error (one cycle)
// marks a rejected misaligned request. o_du_valid (one cycle) marks
// o_du_read_data as valid.
module mem_access_unit #(
    parameter int NB_ADDR     = 32,
    parameter int NB_DATA     = 32,
    parameter int NB_DM_ADDR  = 5,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [1:0]            i_size,
    input  logic                  i_signed,
    input  logic [NB_ADDR-1:0]    i_address,
    input  logic [NB_DATA-1:0]    i_write_data,
    output logic [NB_DATA-1:0]    o_read_data,
    output logic                  o_stall,
    output logic                  o_done,
    output logic                  o_addr_error,
    input  logic                  i_du_flag,
    input  logic                  i_du_read_enable,
    input  logic [NB_DM_ADDR-1:0] i_du_read_address,
    output logic [NB_DATA-1:0]    o_du_read_data,
    output logic                  o_du_valid,
    output logic [1:0]            o_fsm_state
);

    localparam int DEPTH = 1 << NB_DM_ADDR;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [NB_DATA-1:0]  mem [DEPTH];

    logic                  req;
    logic                  is_byte;
    logic                  is_half;
    logic                  is_word;
    logic                  misaligned;
    logic [NB_DM_ADDR-1:0] word_idx;
    logic [1:0]            lane;
    logic                  access_now;
    logic                  mem_we;
    logic [3:0]            byte_en;
    logic [NB_DATA-1:0]    wr_word;
    logic [NB_DATA-1:0]    rd_word;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [NB_DATA-1:0]    load_val;
    logic                  unused_addr_bits;

    // Address bits above the word index are ignored so the memory wraps.
    assign unused_addr_bits = ^i_address[NB_ADDR-1:NB_DM_ADDR+2];

    assign req        = i_valid & (i_mem_read | i_mem_write);
    assign is_byte    = (i_size == 2'b00);
    assign is_half    = (i_size == 2'b01);
    assign is_word    = i_size[1];
    assign misaligned = (is_half & i_address[0]) | (is_word & (|i_address[1:0]));
    assign word_idx   = i_address[NB_DM_ADDR+1:2];
    assign lane       = i_address[1:0];
    assign access_now = (state == BUSY) && (cnt == '0);
    assign mem_we     = access_now & i_valid & i_mem_write;
    assign o_fsm_state = state;

    // Stall covers the accepting IDLE cycle plus every BUSY cycle.
    assign o_stall = (state == BUSY) ||
                     ((state == IDLE) && !i_du_flag && req && !misaligned);

    // Byte-lane enables and lane-replicated store data for the current size.
    always_comb begin
        byte_en = 4'b1111;
        wr_word = i_write_data;
        if (is_byte) begin
            byte_en = 4'b0001 << lane;
            wr_word = {4{i_write_data[7:0]}};
        end else if (is_half) begin
            byte_en = i_address[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{i_write_data[15:0]}};
        end
    end

    // Load lane extraction and sign/zero extension.
    always_comb begin
        rd_word  = mem[word_idx];
        ld_byte  = 8'(rd_word >> {lane, 3'b000});
        ld_half  = i_address[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = rd_word;
        if (is_byte) begin
            load_val = {{24{i_signed & ld_byte[7]}}, ld_byte};
        end else if (is_half) begin
            load_val = {{16{i_signed & ld_half[15]}}, ld_half};
        end
    end

    // Memory array: byte-lane writes on the access edge, never reset.
    always_ff @(posedge i_clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    // Access FSM with latency counter, registered results and pulses.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state          <= IDLE;
            cnt            <= '0;
            o_read_data    <= '0;
            o_du_read_data <= '0;
            o_done         <= 1'b0;
            o_addr_error   <= 1'b0;
            o_du_valid     <= 1'b0;
        end else begin
            o_done       <= 1'b0;
            o_addr_error <= 1'b0;
            o_du_valid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_du_flag) begin
                        if (i_du_read_enable) begin
                            o_du_read_data <= mem[i_du_read_address];
                            o_du_valid     <= 1'b1;
                        end
                    end else if (req) begin
                        if (misaligned) begin
                            o_addr_error <= 1'b1;
                        end else begin
                            cnt   <= CNT_LOAD;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        if (i_valid && i_mem_read && !i_mem_write) begin
                            o_read_data <= load_val;
                        end
                        o_done <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized accesses,
// checked against a byte-array memory model kept in the bench.
module tb_mem_access_unit;

    localparam int NB_ADDR     = 32;
    localparam int NB_DATA     = 32;
    localparam int NB_DM_ADDR  = 5;
    localparam int MEM_LATENCY = 2;
    localparam int MEM_BYTES   = 4 * (1 << NB_DM_ADDR);

    logic                  clk;
    logic                  rst;
    logic                  i_valid;
    logic                  i_mem_read;
    logic                  i_mem_write;
    logic [1:0]            i_size;
    logic                  i_signed;
    logic [NB_ADDR-1:0]    i_address;
    logic [NB_DATA-1:0]    i_write_data;
    logic [NB_DATA-1:0]    o_read_data;
    logic                  o_stall;
    logic                  o_done;
    logic                  o_addr_error;
    logic                  i_du_flag;
    logic                  i_du_read_enable;
    logic [NB_DM_ADDR-1:0] i_du_read_address;
    logic [NB_DATA-1:0]    o_du_read_data;
    logic                  o_du_valid;
    logic [1:0]            o_fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]         model_mem [MEM_BYTES];
    logic [NB_DATA-1:0] last_rd;
    logic [NB_DATA-1:0] exp_q [$];
    logic [NB_DATA-1:0] rdata;

    mem_access_unit #(
        .NB_ADDR    (NB_ADDR),
        .NB_DATA    (NB_DATA),
        .NB_DM_ADDR (NB_DM_ADDR),
        .MEM_LATENCY(MEM_LATENCY)
    ) dut (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_valid          (i_valid),
        .i_mem_read       (i_mem_read),
        .i_mem_write      (i_mem_write),
        .i_size           (i_size),
        .i_signed         (i_signed),
        .i_address        (i_address),
        .i_write_data     (i_write_data),
        .o_read_data      (o_read_data),
        .o_stall          (o_stall),
        .o_done           (o_done),
        .o_addr_error     (o_addr_error),
        .i_du_flag        (i_du_flag),
        .i_du_read_enable (i_du_read_enable),
        .i_du_read_address(i_du_read_address),
        .o_du_read_data   (o_du_read_data),
        .o_du_valid       (o_du_valid),
        .o_fsm_state      (o_fsm_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: plain byte array, little-endian
    function automatic int byte_idx(input logic [31:0] addr);
        return int'(addr) & (MEM_BYTES - 1);
    endfunction

    function automatic logic [31:0] model_word(input int widx);
        int b = (widx * 4) & (MEM_BYTES - 1);
        return {model_mem[b+3], model_mem[b+2], model_mem[b+1], model_mem[b]};
    endfunction

    function automatic bit model_misaligned(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd1) return (addr % 2) != 0;
        if (size >= 2'd2) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                               input logic [31:0] addr);
        int b = byte_idx(addr);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = {24'd0, model_mem[b]};
            if (sgn && model_mem[b][7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = {16'd0, model_mem[b+1], model_mem[b]};
            if (sgn && model_mem[b+1][7]) v = v | 32'hFFFF_0000;
        end else begin
            v = {model_mem[b+3], model_mem[b+2], model_mem[b+1], model_mem[b]};
        end
        return v;
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wd);
        int b = byte_idx(addr);
        int n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) model_mem[b+i] = wd[8*i +: 8];
    endtask

    // Driver: one pipeline access, checked cycle by cycle
    task automatic access(input logic rd, input logic wr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                          input bit du_mid, output logic [31:0] got);
        int stall_cnt = 0;
        int cyc = 0;
        bit got_done = 0;
        logic [31:0] exp;
        @(negedge clk);
        i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr;
        i_size = size; i_signed = sgn; i_address = addr; i_write_data = wd;
        if (model_misaligned(size, addr)) begin
            #1 check("err_stall", o_stall, 0);
            @(negedge clk);
            i_valid = 1'b0;
            #1 check("addr_error", o_addr_error, 1);
            check("err_no_done", o_done, 0);
            @(negedge clk);
            #1 check("err_pulse", o_addr_error, 0);
            check("err_no_done2", o_done, 0);
            got = o_read_data;
            return;
        end
        if (wr) begin
            model_store(size, addr, wd);
            exp = last_rd;
        end else begin
            exp = model_load(size, sgn, addr);
        end
        last_rd = exp;
        exp_q.push_back(exp);
        while (cyc < 20 && !got_done) begin
            #1;
            if (o_done) begin
                got_done = 1;
            end else begin
                if (o_stall) stall_cnt++;
                if (du_mid) check("du_blocked", o_du_valid, 0);
                if (du_mid && cyc == 1) begin
                    i_du_flag = 1'b1;
                    i_du_read_enable = 1'b1;
                    i_du_read_address = addr[NB_DM_ADDR+1:2];
                end
                @(negedge clk);
                cyc++;
            end
        end
        check("done_seen", got_done, 1);
        check("stall_cycles", stall_cnt, 1 + MEM_LATENCY);
        check("done_no_stall", o_stall, 0);
        check("no_addr_err", o_addr_error, 0);
        check("read_data", o_read_data, exp_q.pop_front());
        got = o_read_data;
        i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
        @(negedge clk);
        #1 check("done_pulse", o_done, 0);
    endtask

    // Driver: debug read while a pipeline request is present and ignored
    task automatic du_read(input int widx, input logic [31:0] exp);
        @(negedge clk);
        i_du_flag = 1'b1; i_du_read_enable = 1'b1;
        i_du_read_address = NB_DM_ADDR'(widx);
        i_valid = 1'b1; i_mem_read = 1'b1; i_size = 2'd2; i_address = 32'h4;
        #1 check("du_no_stall", o_stall, 0);
        @(negedge clk);
        i_du_read_enable = 1'b0; i_valid = 1'b0; i_mem_read = 1'b0;
        #1 check("du_valid", o_du_valid, 1);
        check("du_data", o_du_read_data, exp);
        check("du_no_done", o_done, 0);
        @(negedge clk);
        i_du_flag = 1'b0;
        #1 check("du_valid_pulse", o_du_valid, 0);
    endtask

    // Main sequence
    initial begin
        rst = 1'b1;
        i_valid = 0; i_mem_read = 0; i_mem_write = 0; i_size = 0; i_signed = 0;
        i_address = 0; i_write_data = 0;
        i_du_flag = 0; i_du_read_enable = 0; i_du_read_address = 0;
        last_rd = 0;
        repeat (3) @(negedge clk);
        #1 check("rst_read_data", o_read_data, 0);
        check("rst_du_data", o_du_read_data, 0);
        check("rst_done", o_done, 0);
        check("rst_addr_err", o_addr_error, 0);
        check("rst_du_valid", o_du_valid, 0);
        check("rst_stall", o_stall, 0);
        @(negedge clk);
        rst = 1'b0;

        // Fill memory so the model and DUT agree on every byte
        for (int i = 0; i < (1 << NB_DM_ADDR); i++)
            access(0, 1, 2'd2, 0, 32'(i * 4), $urandom, 0, rdata);

        // Word store and load back
        access(0, 1, 2'd2, 0, 32'h8, 32'hDEADBEEF, 0, rdata);
        access(1, 0, 2'd2, 0, 32'h8, 0, 0, rdata);
        check("ld_word_8", rdata, 32'hDEADBEEF);

        // Byte store then mixed loads
        access(0, 1, 2'd0, 0, 32'h9, 32'h000000A5, 0, rdata);
        access(1, 0, 2'd2, 0, 32'h8, 0, 0, rdata);
        check("ld_word_after_byte", rdata, 32'hDEADA5EF);
        access(1, 0, 2'd0, 1, 32'h9, 0, 0, rdata);
        check("ld_sbyte", rdata, 32'hFFFFFFA5);
        access(1, 0, 2'd0, 0, 32'h9, 0, 0, rdata);
        check("ld_ubyte", rdata, 32'h000000A5);
        access(1, 0, 2'd1, 1, 32'hA, 0, 0, rdata);
        check("ld_shalf", rdata, 32'hFFFFDEAD);

        // Misaligned requests leave memory untouched
        access(1, 0, 2'd1, 0, 32'h3, 0, 0, rdata);
        access(0, 1, 2'd2, 0, 32'h2, 32'h55555555, 0, rdata);
        access(1, 0, 2'd2, 0, 32'h0, 0, 0, rdata);

        // Debug read of word 2
        du_read(2, 32'hDEADA5EF);

        // Debug request raised mid-access is served after DONE
        access(0, 1, 2'd2, 0, 32'h14, 32'h11223344, 1, rdata);
        #0 check("du_wait_idle", o_du_valid, 0);
        @(negedge clk);
        i_du_flag = 1'b0; i_du_read_enable = 1'b0;
        #1 check("du_mid_valid", o_du_valid, 1);
        check("du_mid_data", o_du_read_data, 32'h11223344);

        // Both read and write set: a store, read data holds
        access(1, 1, 2'd2, 0, 32'h18, 32'h0F0F0F0F, 0, rdata);

        // Reset in BUSY aborts the store
        access(0, 1, 2'd2, 0, 32'h10, 32'h0BADF00D, 0, rdata);
        access(1, 0, 2'd2, 0, 32'h10, 0, 0, rdata);
        @(negedge clk);
        i_valid = 1'b1; i_mem_write = 1'b1; i_size = 2'd2;
        i_address = 32'h10; i_write_data = 32'h12345678;
        @(negedge clk);
        #2 rst = 1'b1;
        i_valid = 1'b0; i_mem_write = 1'b0;
        #1 check("mid_rst_read_data", o_read_data, 0);
        check("mid_rst_du_data", o_du_read_data, 0);
        check("mid_rst_done", o_done, 0);
        check("mid_rst_addr_err", o_addr_error, 0);
        check("mid_rst_du_valid", o_du_valid, 0);
        check("mid_rst_stall", o_stall, 0);
        @(negedge clk);
        rst = 1'b0;
        last_rd = 0;
        repeat (3) @(negedge clk);
        #1 check("mid_rst_no_done", o_done, 0);
        access(1, 0, 2'd2, 0, 32'h10, 0, 0, rdata);
        check("ld_after_abort", rdata, 32'h0BADF00D);

        // Address wrap
        access(0, 1, 2'd2, 0, 32'h80, 32'hCAFEF00D, 0, rdata);
        access(1, 0, 2'd2, 0, 32'h0, 0, 0, rdata);
        check("ld_wrap", rdata, 32'hCAFEF00D);

        // Randomized accesses against the model
        for (int n = 0; n < 100; n++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            int          op;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz >= 2'd2) a[1:0] = 2'b00;
            end
            op = $urandom_range(0, 3);
            access((op == 0 || op == 1 || op == 3) ? 1'b1 : 1'b0,
                   (op >= 2) ? 1'b1 : 1'b0,
                   sz, 1'($urandom_range(0, 1)), a, $urandom, 0, rdata);
            if (n % 10 == 9) begin
                int w;
                w = $urandom_range(0, (1 << NB_DM_ADDR) - 1);
                du_read(w, model_word(w));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
